// File: rtl/instr_encoder_loader_if.sv
// Instruction encoder/loader bus bundle.
// Groups the field-tuple input stream and the instruction-memory write port.
//   Stream : in_valid, in_ready, in_last, itype, opcode, funct, rs, rt, rd,
//            imm, jmp
//   Memory : mem_we, mem_addr, mem_wdata
// master: producer of tuples / consumer of the write port (bench, boot ctrl).
// slave : the loader itself.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [1:0]               itype;
  logic [5:0]               opcode;
  logic [5:0]               funct;
  logic [3:0]               rs;
  logic [3:0]               rt;
  logic [3:0]               rd;
  logic signed [31:0]       imm;
  logic signed [31:0]       jmp;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [31:0]              mem_wdata;

  modport master (
    output in_valid, in_last, itype, opcode, funct, rs, rt, rd, imm, jmp,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, itype, opcode, funct, rs, rt, rd, imm, jmp,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs decoded instruction field tuples into 32-bit words (same layout that
// instruction_memory decodes) and writes them to consecutive word addresses.
// One word is accepted and written every two cycles (LOAD -> WRITE).
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   start      pulse, opens a session at base_addr (ignored unless idle)
//   base_addr  first word address of the session
//   bus        instr_encoder_loader_if.slave: tuple stream + memory write port
//   busy       high in LOAD and WRITE
//   done       one-cycle pulse at session end
//   err_code   00 none, 01 imm range, 10 jmp range, 11 memory overflow
//   word_count words written in the current/last session
//
// Optional feature: define ENCODER_RANGE_CHECK_EN to reject I-type immediates
// that do not fit 18 signed bits and J-type offsets that do not fit 26 signed
// bits. Without it those fields are silently truncated.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_count
);

  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   wdata_p0, wdata_d;
  logic                last_p0, last_d;
  logic [1:0]          range_err;

  // Field packing; reserved itype 11 falls through to the R layout.
  function automatic logic [DATA_W-1:0] encode_word(
    input logic [1:0]         itype,
    input logic [5:0]         opcode,
    input logic [5:0]         funct,
    input logic [3:0]         rs,
    input logic [3:0]         rt,
    input logic [3:0]         rd,
    input logic signed [31:0] imm,
    input logic signed [31:0] jmp
  );
    logic [DATA_W-1:0] w;
    case (itype)
      2'b01:   w = {opcode, rs, rt, imm[17:0]};
      2'b10:   w = {opcode, jmp[25:0]};
      default: w = {opcode, rs, rt, rd, 8'b0, funct};
    endcase
    return w;
  endfunction

`ifdef ENCODER_RANGE_CHECK_EN
  function automatic logic imm_fits(input logic signed [31:0] v);
    return (v >= -32'sd131072) && (v <= 32'sd131071);
  endfunction

  function automatic logic jmp_fits(input logic signed [31:0] v);
    return (v >= -32'sd33554432) && (v <= 32'sd33554431);
  endfunction

  always_comb begin
    range_err = 2'b00;
    if (bus.itype == 2'b01 && !imm_fits(bus.imm)) begin
      range_err = 2'b01;
    end else if (bus.itype == 2'b10 && !jmp_fits(bus.jmp)) begin
      range_err = 2'b10;
    end
  end
`else
  // Upper immediate/offset bits are dropped by design when checks are off.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{bus.imm[31:18], bus.jmp[31:26]};
  assign range_err      = 2'b00;
`endif

  // Stage p0: registered control state, encoded word and last flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 2'b00;
      wdata_p0 <= '0;
      last_p0  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wdata_p0 <= wdata_d;
      last_p0  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    err_d        = err_q;
    wdata_d      = wdata_p0;
    last_d       = last_p0;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 2'b00;
        end
      end

      S_LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid) begin
          if (range_err != 2'b00) begin
            // Offending tuple is consumed but never reaches memory.
            err_d   = range_err;
            state_d = S_DONE;
          end else begin
            wdata_d = encode_word(bus.itype, bus.opcode, bus.funct, bus.rs,
                                  bus.rt, bus.rd, bus.imm, bus.jmp);
            last_d  = bus.in_last;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        count_d    = count_q + 1'b1;
        addr_d     = addr_q + 1'b1;
        if (last_p0) begin
          state_d = S_DONE;
        end else if (addr_q == LAST_ADDR || addr_q == TOP_ADDR) begin
          // No room for another word: end the session instead of wrapping.
          err_d   = 2'b11;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_p0;
  assign err_code      = err_q;
  assign word_count    = count_q;

endmodule
